// File: rtl/text_dump_pkg.sv
// rtl/text_dump_pkg.sv - shared protocol constants, RAM field positions and dump FSM encoding
//
// Purpose: constants shared by the screen read-back engine and the terminal's UART
// byte decoder, so both ends agree on the byte protocol and text RAM word layout.
// Ports: none (package).
package text_dump_pkg;

    // Byte protocol understood by the terminal's UART input
    localparam logic [7:0] CMD_NEWLINE     = 8'h0D;
    localparam logic [7:0] CMD_BACKSPACE   = 8'h7F;
    localparam int         COLOUR_FLAG_BIT = 7;
    localparam logic [7:0] COLOUR_FLAG     = 8'h80;

    // Text RAM word layout
    localparam int ATTR_MSB = 15;
    localparam int ATTR_LSB = 8;
    localparam int CHAR_MSB = 7;
    localparam int CHAR_LSB = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_CHECK,
        ST_SEND_COL,
        ST_WAIT_COL,
        ST_SEND_CHR,
        ST_WAIT_CHR,
        ST_SEND_CR,
        ST_WAIT_CR,
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/text_dump_map.sv
// rtl/text_dump_map.sv - character substitution and colour-command byte formatter
//
// Purpose: turns a stored cell into the bytes the terminal decoder will accept.
// Ports:
//   i_char        stored character byte
//   i_attr        attribute bits [6:0] (bit 7 is never transmitted)
//   o_char_byte   character to send; control-code aliases replaced by SUB_CHAR
//   o_colour_byte colour command byte (flag bit set, attribute in [6:0])
module text_dump_map
    import text_dump_pkg::*;
#(
    parameter logic [7:0] SUB_CHAR = 8'h3F
) (
    input  logic [7:0] i_char,
    input  logic [6:0] i_attr,
    output logic [7:0] o_char_byte,
    output logic [7:0] o_colour_byte
);

    logic w_alias;

    // Anything the decoder would interpret as a command must not pass through raw
    assign w_alias = (i_char == CMD_NEWLINE) || (i_char == CMD_BACKSPACE) ||
                     i_char[COLOUR_FLAG_BIT];

    assign o_char_byte   = w_alias ? SUB_CHAR : i_char;
    assign o_colour_byte = COLOUR_FLAG | {1'b0, i_attr};

endmodule

// File: rtl/text_dump_tx.sv
// rtl/text_dump_tx.sv - text RAM read-back engine serialising the screen as UART bytes
//
// Purpose: on Start_i walks the text RAM row by row, emitting a colour command
// whenever the attribute changes (always before the first cell), each mapped
// character, and a newline after every row, using the UartTx Start/Done handshake.
// Ports:
//   Clock, Reset          clock, asynchronous active-high reset
//   Start_i               dump request (accepted in IDLE only)
//   Busy_o, Done_o        dump in progress / one-cycle completion pulse
//   RamAddr_o, RamData_i  text RAM read port (1-cycle read latency)
//   TxStart_o, TxData_o   byte request to UartTx
//   TxDone_i              UartTx completion pulse
module text_dump_tx
    import text_dump_pkg::*;
#(
    parameter int         COLUMNS    = 80,
    parameter int         ROWS       = 30,
    parameter int         ADDR_WIDTH = 12,
    parameter logic [7:0] SUB_CHAR   = 8'h3F
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic [ADDR_WIDTH-1:0] RamAddr_o,
    input  logic [15:0]           RamData_i,
    output logic                  TxStart_o,
    output logic [7:0]            TxData_o,
    input  logic                  TxDone_i
);

    localparam int COL_W = $clog2(COLUMNS + 1);
    localparam int ROW_W = $clog2(ROWS + 1);

    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(COLUMNS - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]      COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]      ROW_ONE  = ROW_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    dump_state_t      r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [7:0]       r_attr;
    logic [7:0]       r_char;
    logic [7:0]       r_last_attr;
    logic             r_force_colour;

    logic [7:0] w_char_byte;
    logic [7:0] w_colour_byte;
    logic       w_tx_done;

    text_dump_map #(
        .SUB_CHAR (SUB_CHAR)
    ) u_map (
        .i_char        (r_char),
        .i_attr        (r_attr[6:0]),
        .o_char_byte   (w_char_byte),
        .o_colour_byte (w_colour_byte)
    );

    // A completion pulse coinciding with our own start pulse cannot belong to
    // the byte just requested, so it is not taken as that byte's Done.
    assign w_tx_done = TxDone_i && !TxStart_o;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_attr         <= '0;
            r_char         <= '0;
            r_last_attr    <= '0;
            r_force_colour <= 1'b1;
            Busy_o         <= 1'b0;
            Done_o         <= 1'b0;
            RamAddr_o      <= '0;
            TxStart_o      <= 1'b0;
            TxData_o       <= 8'h00;
        end else begin
            TxStart_o <= 1'b0;
            Done_o    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start_i) begin
                        RamAddr_o      <= '0;
                        r_col          <= '0;
                        r_row          <= '0;
                        r_force_colour <= 1'b1;
                        Busy_o         <= 1'b1;
                        r_state        <= ST_READ;
                    end
                end
                // Address is already registered; this cycle presents it to the RAM
                ST_READ: r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_attr  <= RamData_i[ATTR_MSB:ATTR_LSB];
                    r_char  <= RamData_i[CHAR_MSB:CHAR_LSB];
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (r_force_colour || (r_attr != r_last_attr)) begin
                        r_state <= ST_SEND_COL;
                    end else begin
                        r_state <= ST_SEND_CHR;
                    end
                end
                ST_SEND_COL: begin
                    TxStart_o      <= 1'b1;
                    TxData_o       <= w_colour_byte;
                    r_last_attr    <= r_attr;
                    r_force_colour <= 1'b0;
                    r_state        <= ST_WAIT_COL;
                end
                ST_WAIT_COL: begin
                    if (w_tx_done) begin
                        r_state <= ST_SEND_CHR;
                    end
                end
                ST_SEND_CHR: begin
                    TxStart_o <= 1'b1;
                    TxData_o  <= w_char_byte;
                    r_state   <= ST_WAIT_CHR;
                end
                ST_WAIT_CHR: begin
                    if (w_tx_done) begin
                        if (r_col == COL_LAST) begin
                            r_state <= ST_SEND_CR;
                        end else begin
                            r_col     <= r_col + COL_ONE;
                            RamAddr_o <= RamAddr_o + ADDR_ONE;
                            r_state   <= ST_READ;
                        end
                    end
                end
                ST_SEND_CR: begin
                    TxStart_o <= 1'b1;
                    TxData_o  <= CMD_NEWLINE;
                    r_state   <= ST_WAIT_CR;
                end
                ST_WAIT_CR: begin
                    if (w_tx_done) begin
                        if (r_row == ROW_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_col     <= '0;
                            r_row     <= r_row + ROW_ONE;
                            RamAddr_o <= RamAddr_o + ADDR_ONE;
                            r_state   <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    Done_o  <= 1'b1;
                    Busy_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_dump_tx.sv
// tb/tb_text_dump_tx.sv - self-checking bench for text_dump_tx (4x2 and 80x30 instances)
module tb_text_dump_tx;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        start_s = 1'b0;
    logic        start_f = 1'b0;
    logic        TxDone_i = 1'b0;
    logic        sel = 1'b0;
    logic        spur_en = 1'b0;

    logic        busy_s, done_s, ts_s;
    logic [7:0]  td_s;
    logic [2:0]  addr_s;
    logic [15:0] rd_s;
    logic        busy_f, done_f, ts_f;
    logic [7:0]  td_f;
    logic [11:0] addr_f;
    logic [15:0] rd_f;

    logic [15:0] mem [0:4095];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    int vectors = 0;
    int errors = 0;
    int nd_s = 0;
    int nd_f = 0;

    text_dump_tx #(.COLUMNS(4), .ROWS(2), .ADDR_WIDTH(3), .SUB_CHAR(8'h3F)) u_small (
        .Clock(Clock), .Reset(Reset), .Start_i(start_s), .Busy_o(busy_s), .Done_o(done_s),
        .RamAddr_o(addr_s), .RamData_i(rd_s), .TxStart_o(ts_s), .TxData_o(td_s),
        .TxDone_i(TxDone_i));

    text_dump_tx u_full (
        .Clock(Clock), .Reset(Reset), .Start_i(start_f), .Busy_o(busy_f), .Done_o(done_f),
        .RamAddr_o(addr_f), .RamData_i(rd_f), .TxStart_o(ts_f), .TxData_o(td_f),
        .TxDone_i(TxDone_i));

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        rd_s <= mem[addr_s];
        rd_f <= mem[addr_f];
    end

    always @(negedge Clock) begin
        if (done_s) nd_s++;
        if (done_f) nd_f++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART stand-in: records each requested byte, answers with Done after a random delay
    always begin : responder
        bit pend;
        int dly;
        logic w_start;
        logic [7:0] w_data;
        pend = 1'b0;
        dly = 0;
        forever begin
            @(posedge Clock);
            #1;
            TxDone_i = 1'b0;
            w_start = sel ? ts_f : ts_s;
            w_data  = sel ? td_f : td_s;
            if (Reset) begin
                pend = 1'b0;
            end else if (w_start) begin
                chk("tx_pulse_while_pending", {31'd0, pend}, 32'd0);
                got.push_back(w_data);
                pend = 1'b1;
                dly = $urandom_range(0, 3);
            end else if (pend) begin
                if (dly == 0) begin
                    TxDone_i = 1'b1;
                    pend = 1'b0;
                end else begin
                    dly--;
                end
            end else if (spur_en && ($urandom_range(0, 2) == 0)) begin
                TxDone_i = 1'b1;
            end
        end
    end

    // Expected stream straight from the protocol rules
    function automatic void build_exp(input int cols, input int rows);
        logic [7:0] a, c, last;
        bit first;
        exp_q.delete();
        first = 1'b1;
        last = 8'h00;
        for (int r = 0; r < rows; r++) begin
            for (int col = 0; col < cols; col++) begin
                a = mem[r * cols + col][15:8];
                c = mem[r * cols + col][7:0];
                if (first || a != last) exp_q.push_back({1'b1, a[6:0]});
                first = 1'b0;
                last = a;
                if (c == 8'h0D || c == 8'h7F || c >= 8'h80) exp_q.push_back(8'h3F);
                else exp_q.push_back(c);
            end
            exp_q.push_back(8'h0D);
        end
    endfunction

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy_s, 1'b0);
        chk({tag, "_done"}, done_s, 1'b0);
        chk({tag, "_txstart"}, ts_s, 1'b0);
        chk({tag, "_txdata"}, td_s, 8'h00);
        chk({tag, "_addr"}, addr_s, 3'd0);
    endtask

    task automatic run_dump(input bit full, input bit spam, input int limit, input string tag);
        int cyc;
        got.delete();
        nd_s = 0;
        nd_f = 0;
        sel = full;
        @(negedge Clock);
        if (full) start_f = 1'b1; else start_s = 1'b1;
        @(negedge Clock);
        start_f = 1'b0;
        start_s = 1'b0;
        chk({tag, "_busy_after_start"}, full ? busy_f : busy_s, 1'b1);
        cyc = 0;
        while (cyc < limit) begin
            @(negedge Clock);
            if (full ? done_f : done_s) break;
            if (full) start_f = spam && busy_f && ($urandom_range(0, 2) == 0);
            else      start_s = spam && busy_s && ($urandom_range(0, 2) == 0);
            cyc++;
        end
        start_f = 1'b0;
        start_s = 1'b0;
        chk({tag, "_no_timeout"}, cyc < limit, 1'b1);
        repeat (4) @(negedge Clock);
        chk({tag, "_done_pulses"}, full ? nd_f : nd_s, 1);
        chk({tag, "_busy_low"}, full ? busy_f : busy_s, 1'b0);
        build_exp(full ? 80 : 4, full ? 30 : 2);
        compare_stream(tag);
    endtask

    initial begin
        string s;
        int cyc;
        s = "ABCDEFGH";
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge Clock);
        chk_reset_outputs("reset");
        chk("reset_full_busy", busy_f, 1'b0);
        chk("reset_full_addr", addr_f, 12'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Uniform attribute, plain text
        for (int i = 0; i < 8; i++) mem[i] = {8'h41, s[i]};
        run_dump(1'b0, 1'b0, 2000, "uniform");
        chk("uniform_len_const", got.size(), 11);
        if (got.size() > 5) begin
            chk("uniform_first", got[0], 8'hC1);
            chk("uniform_cr", got[5], 8'h0D);
        end

        // Attribute change on one cell
        mem[2] = {8'h22, s[2]};
        run_dump(1'b0, 1'b0, 2000, "attrchg");
        chk("attrchg_len_const", got.size(), 13);
        if (got.size() > 5) chk("attrchg_col", got[3], 8'hA2);

        // Control-code aliases
        for (int i = 0; i < 8; i++) mem[i] = {8'h41, 8'h45};
        mem[0][7:0] = 8'h0D;
        mem[1][7:0] = 8'h7F;
        mem[2][7:0] = 8'h9A;
        mem[3][7:0] = 8'h01;
        run_dump(1'b0, 1'b0, 2000, "subst");
        if (got.size() > 4) begin
            chk("subst_0d", got[1], 8'h3F);
            chk("subst_7f", got[2], 8'h3F);
            chk("subst_9a", got[3], 8'h3F);
            chk("subst_01", got[4], 8'h01);
        end

        // Random screens with Start spam and spurious TxDone
        spur_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++)
                mem[i] = {($urandom_range(0, 1) != 0) ? 8'h41 : 8'($urandom), 8'($urandom)};
            run_dump(1'b0, 1'b1, 2000, $sformatf("rand%0d", n));
        end
        spur_en = 1'b0;

        // Reset in the cycle of the 5th byte request
        got.delete();
        nd_s = 0;
        sel = 1'b0;
        @(negedge Clock);
        start_s = 1'b1;
        @(negedge Clock);
        start_s = 1'b0;
        cyc = 0;
        while (got.size() < 5 && cyc < 500) begin
            @(posedge Clock);
            #2;
            cyc++;
        end
        chk("midreset_reached5", got.size(), 5);
        Reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk("midreset_no_done", nd_s, 0);
        for (int i = 0; i < 8; i++) mem[i] = {8'h41, 8'($urandom_range(8'h20, 8'h7E))};
        run_dump(1'b0, 1'b0, 2000, "restart");

        // Full default geometry, uniform attribute
        for (int i = 0; i < 2400; i++) mem[i] = {8'h07, 8'($urandom)};
        run_dump(1'b1, 1'b0, 60000, "full");
        chk("full_len_const", got.size(), 2431);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/text_dump_tx.md
Name: text_dump_tx

Overview:
- Screen read-back engine for the VGA text terminal: on request, walks the text RAM cell by cell and serialises it as a UART byte stream.
- The stream uses the same byte protocol the terminal's UART input accepts, so it can be replayed into the terminal to reproduce the screen.
  - Colour command: bit7 = 1.
  - New line: 8'h0D.
- Sits between a second read port of the text RAM and an instance of UartTx, using UartTx's Start/Done handshake.

Parameters:
- COLUMNS, 80, characters per row.
- ROWS, 30, rows per screen.
- ADDR_WIDTH, 12, text RAM address width; must satisfy 2**ADDR_WIDTH >= COLUMNS*ROWS.
- SUB_CHAR, 8'h3F, byte sent in place of any stored character that would alias a control code.

Ports:
- Clock, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, asynchronous, active-high.
- Start_i, input, 1, one-cycle request to begin a dump; sampled only in IDLE.
- Busy_o, output, 1, high from the cycle after Start_i is accepted until Done_o.
- Done_o, output, 1, one-cycle pulse after the final byte's TxDone_i.
- RamAddr_o, output, ADDR_WIDTH, text RAM read address, linear: row*COLUMNS + column.
- RamData_i, input, 16, read data with 1-cycle synchronous latency; [15:8] attribute, [7:0] character.
- TxStart_o, output, 1, one-cycle pulse to UartTx.
- TxData_o, output, 8, byte to transmit; valid in the TxStart_o cycle and held until the next pulse.
- TxDone_i, input, 1, UartTx completion pulse.

Behaviour:
- Reset values: Busy_o=0, Done_o=0, TxStart_o=0, TxData_o=8'h00, RamAddr_o=0. Internal state: IDLE, column=0, row=0, LastAttr=0, ForceColour=1.
- FSM states and transitions:
  - IDLE: on Start_i, clear address/column/row, set ForceColour=1, then go to READ.
  - READ: drive RamAddr_o, then go to LATCH.
  - LATCH: wait one cycle for RAM latency, capture RamData_i, then go to CHECK.
  - CHECK: if ForceColour or attribute != LastAttr, go to SEND_COL; else go to SEND_CHR.
  - SEND_COL: emit 8'h80 | attr[6:0]; set LastAttr=attr and ForceColour=0; then go to WAIT_COL.
  - WAIT_COL: wait for TxDone_i, then go to SEND_CHR.
  - SEND_CHR: emit the mapped character, then go to WAIT_CHR.
  - WAIT_CHR: on TxDone_i:
    - column == COLUMNS-1: go to SEND_CR.
    - otherwise: increment column and address, then go to READ.
  - SEND_CR: emit 8'h0D, then go to WAIT_CR.
  - WAIT_CR: on TxDone_i:
    - row == ROWS-1: go to DONE.
    - otherwise: column=0, increment row and address, then go to READ.
  - DONE: pulse Done_o for one cycle, then return to IDLE.
- Character mapping: chars 8'h0D, 8'h7F and 8'h80..8'hFF become SUB_CHAR; all others (including 8'h00..8'h0C and 8'h01 glyphs) pass unchanged.
- Colour command carries attr[6:0]; attr[7] is not transmitted.
- Each TxStart_o pulse lasts exactly one cycle. Exactly one pulse per byte. No new pulse before TxDone_i for the previous byte.
- TxDone_i outside the WAIT_* states is ignored.
- Start_i outside IDLE is ignored; no queuing.
- Start_i in the same cycle as the DONE→IDLE transition is ignored. Start_i is accepted from the first IDLE cycle.
- Byte count per dump = COLUMNS*ROWS characters + ROWS CRs + number of colour commands (at least 1). Uniform 80x30 screen → 2431 bytes.
- Reset mid-dump: immediate return to IDLE; TxStart_o drops asynchronously; no Done_o. A byte already in UartTx is that block's concern.
- Address arithmetic: RamAddr_o counts linearly; column and row counters are separate; no multiplier.

Decomposition:
- Shared package holds:
  - Protocol constants: CMD_NEWLINE=8'h0D, CMD_BACKSPACE=8'h7F, COLOUR_FLAG bit 7.
  - Text RAM field positions: ATTR [15:8], CHAR [7:0].
  - The FSM state encoding.
  - The receiving terminal decoder uses the same constants.
- One natural sub-module: text_dump_map, the combinational character-substitution and colour-byte formatter.

Test Plan:
- COLUMNS=4, ROWS=2; RAM = "ABCD","EFGH", all attr 8'h41; pulse Start_i → bytes 8'hC1,A,B,C,D,0D,E,F,G,H,0D; then Done_o pulse; Busy_o low afterwards.
- Same geometry; cell 2 attr 8'h22, others 8'h41 → 8'hC1,A,B,8'hA2,C,8'hC1,D,0D,... (13 bytes).
- Cells containing 8'h0D, 8'h7F, 8'h9A, 8'h01 → 3F,3F,3F,01; 8'h01 passes unchanged.
- Start_i pulsed repeatedly while Busy_o=1 → single stream of identical length. Spurious TxDone_i during READ → no skipped byte or extra byte.
- Reset asserted after the 5th TxStart_o → all outputs at reset values in the same cycle; no Done_o. A fresh Start_i restarts at address 0 with a forced colour byte.
- Default 80x30, uniform attr, closed loop through UartTx + top → exactly 2431 TxStart_o pulses; terminal text RAM identical to source after replay.
